mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between the fetch requester and the load/store requester.
- Drives the memory's address, data_in, read_write and data_out interface, which has combinational read, word-wide write on the clock edge and byte-addressed little-endian storage.
- Round-robin arbitrates between the two requesters and returns registered responses.
- Performs read-modify-write for partial-word stores and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port instruction/data memory between the fetch and
// load/store requesters. Requests are granted round-robin, reads and full-word
// stores complete in one cycle, and partial-word stores take an extra cycle to
// read-modify-write. Misaligned or out-of-range accesses are answered with an
// error and never write memory. Responses are registered one-cycle pulses.

module mem_port_arbiter #(
    parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,

    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wmask,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);

    // Highest byte address at which a full word still fits in memory.
    localparam logic [31:0] MEM_LAST = MEM_BASE + 32'(MEM_DEPTH) - 32'd4;

    typedef enum logic {
        ST_IDLE,
        ST_MERGE
    } state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    state_t      state_q;
    grant_t      last_grant_q;
    logic [31:0] mem_addr_q;

    logic        if_resp_valid_q;
    logic [31:0] if_resp_data_q;
    logic        if_resp_err_q;
    logic        d_resp_valid_q;
    logic [31:0] d_resp_data_q;
    logic        d_resp_err_q;

    // Partial-store context held across the MERGE cycle.
    logic [31:0] merge_addr_q;
    logic [31:0] merge_old_q;
    logic [31:0] merge_wdata_q;
    logic [3:0]  merge_mask_q;

    logic        grant_if;
    logic        grant_d;
    logic        if_err;
    logic        d_err;
    logic        d_full_store;
    logic        d_partial_store;
    logic [31:0] merge_word;

    // Misaligned, below the memory window, or with its last byte past the end.
    function automatic logic access_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < MEM_BASE) || (addr > MEM_LAST);
    endfunction

    assign if_err          = access_err(if_req_addr);
    assign d_err           = access_err(d_req_addr);
    assign d_full_store    = d_req_we && (d_req_wmask == 4'hF);
    assign d_partial_store = d_req_we && (d_req_wmask != 4'h0) && (d_req_wmask != 4'hF);

    // Round-robin arbitration: on a tie the port that did not win last time is granted.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset && state_q == ST_IDLE) begin
            if (if_req_valid && d_req_valid) begin
                if (last_grant_q == GRANT_FETCH) begin
                    grant_d = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else begin
                grant_if = if_req_valid;
                grant_d  = d_req_valid;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // Byte-lane merge of the store data into the word read at acceptance.
    always_comb begin
        merge_word = merge_old_q;
        for (int i = 0; i < 4; i++) begin
            if (merge_mask_q[i]) begin
                merge_word[8*i +: 8] = merge_wdata_q[8*i +: 8];
            end
        end
    end

    // Memory port drive: MERGE writes the merged word, a grant presents its address.
    always_comb begin
        mem_address    = mem_addr_q;
        mem_data_in    = 32'h0;
        mem_read_write = 1'b0;
        if (state_q == ST_MERGE) begin
            mem_address    = merge_addr_q;
            mem_data_in    = merge_word;
            mem_read_write = 1'b1;
        end else if (grant_if) begin
            mem_address = if_req_addr;
        end else if (grant_d) begin
            mem_address = d_req_addr;
            if (d_full_store && !d_err) begin
                mem_data_in    = d_req_wdata;
                mem_read_write = 1'b1;
            end
        end
    end

    // Control FSM with registered responses and the held memory address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= GRANT_FETCH;
            mem_addr_q      <= MEM_BASE;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= 32'h0;
            if_resp_err_q   <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_data_q   <= 32'h0;
            d_resp_err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mem_addr_q      <= mem_address;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= 32'h0;
            if_resp_err_q   <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_data_q   <= 32'h0;
            d_resp_err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_if) begin
                        last_grant_q    <= GRANT_FETCH;
                        if_resp_valid_q <= 1'b1;
                        if_resp_err_q   <= if_err;
                        if_resp_data_q  <= if_err ? 32'h0 : mem_data_out;
                    end else if (grant_d) begin
                        last_grant_q <= GRANT_DATA;
                        if (d_err) begin
                            d_resp_valid_q <= 1'b1;
                            d_resp_err_q   <= 1'b1;
                        end else if (!d_req_we) begin
                            d_resp_valid_q <= 1'b1;
                            d_resp_data_q  <= mem_data_out;
                        end else if (d_partial_store) begin
                            state_q <= ST_MERGE;
                        end else begin
                            // Full-word and zero-mask stores answer immediately.
                            d_resp_valid_q <= 1'b1;
                        end
                    end
                end

                ST_MERGE: begin
                    state_q        <= ST_IDLE;
                    d_resp_valid_q <= 1'b1;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Capture the partial-store context at acceptance for use in MERGE.
    always_ff @(posedge clock) begin
        // NOTE: no reset here; these registers are only read in MERGE, which is entered only after they are loaded.
        if (grant_d && !d_err && d_partial_store) begin
            merge_addr_q  <= d_req_addr;
            merge_old_q   <= mem_data_out;
            merge_wdata_q <= d_req_wdata;
            merge_mask_q  <= d_req_wmask;
        end
    end

    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign if_resp_err   = if_resp_err_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;
    assign d_resp_err    = d_resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The bench owns a byte-addressed
// memory wired to the DUT and keeps a word-level reference model that decides,
// cycle by cycle, which port must be granted, when memory must be written and
// which responses must appear. Literal checks pin the model's results.

module tb_mem_port_arbiter;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_resp_err;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wmask;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .if_resp_err    (if_resp_err),
        .d_req_valid    (d_req_valid),
        .d_req_addr     (d_req_addr),
        .d_req_we       (d_req_we),
        .d_req_wdata    (d_req_wdata),
        .d_req_wmask    (d_req_wmask),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .d_resp_err     (d_resp_err),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------- memory
    logic [7:0] tb_mem [0:DEPTH-1];

    always_comb begin
        logic [31:0] off;
        off = mem_address - BASE;
        if (off <= 32'(DEPTH - 4)) begin
            mem_data_out = {tb_mem[off + 3], tb_mem[off + 2], tb_mem[off + 1], tb_mem[off]};
        end else begin
            mem_data_out = 32'h0;
        end
    end

    always @(posedge clock) begin
        logic [31:0] off;
        off = mem_address - BASE;
        if (mem_read_write && off <= 32'(DEPTH - 4)) begin
            for (int b = 0; b < 4; b++) tb_mem[off + 32'(b)] <= mem_data_in[8*b +: 8];
        end
    end

    function automatic logic [31:0] tb_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return {tb_mem[off + 3], tb_mem[off + 2], tb_mem[off + 1], tb_mem[off]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        bit          is_d;
        int          due;
        logic [31:0] data;
        bit          err;
        int          acc;
    } resp_t;

    logic [31:0] ref_mem [0:DEPTH/4-1];
    resp_t       rq [$];
    int          cyc = 0;
    bit          m_last_d;
    int          m_merge_cyc = -1;
    int          m_merge_acc;
    logic [31:0] m_pw_addr;
    logic [31:0] m_pw_data;

    // Values the model expected at the most recent response on each port.
    logic [31:0] last_if_data, last_d_data;
    bit          last_if_err, last_d_err;
    int          last_if_cyc, last_d_cyc, last_d_lat;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a < BASE) || (a > BASE + DEPTH - 4);
    endfunction

    function automatic resp_t mk(input bit is_d, input int due, input logic [31:0] data,
                                 input bit err, input int acc);
        resp_t r;
        r.is_d = is_d; r.due = due; r.data = data; r.err = err; r.acc = acc;
        return r;
    endfunction

    task automatic model_step();
        bit          exp_ifv, exp_dv, gi, gd, merge, e, exp_rw;
        logic [31:0] exp_ifd, exp_dd, exp_addr, exp_din, old, wd;
        bit          exp_ife, exp_de;
        int          idx;

        cyc++;
        if (reset) begin
            check("rst_if_resp_valid", 32'(if_resp_valid), 32'd0);
            check("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
            check("rst_if_resp_data", if_resp_data, 32'h0);
            check("rst_d_resp_err", 32'(d_resp_err), 32'd0);
            check("rst_mem_rw", 32'(mem_read_write), 32'd0);
            check("rst_mem_address", mem_address, BASE);
            check("rst_mem_data_in", mem_data_in, 32'h0);
            rq.delete();
            m_merge_cyc = -1;
            m_last_d    = 1'b0;
            return;
        end

        // Responses due this cycle.
        exp_ifv = 0; exp_dv = 0; exp_ifd = 0; exp_dd = 0; exp_ife = 0; exp_de = 0;
        for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].due == cyc) begin
                if (rq[i].is_d) begin
                    exp_dv = 1; exp_dd = rq[i].data; exp_de = rq[i].err;
                    last_d_data = rq[i].data; last_d_err = rq[i].err;
                    last_d_cyc = cyc; last_d_lat = cyc - rq[i].acc;
                end else begin
                    exp_ifv = 1; exp_ifd = rq[i].data; exp_ife = rq[i].err;
                    last_if_data = rq[i].data; last_if_err = rq[i].err;
                    last_if_cyc = cyc;
                end
                rq.delete(i);
            end
        end
        check("if_resp_valid", 32'(if_resp_valid), 32'(exp_ifv));
        check("d_resp_valid", 32'(d_resp_valid), 32'(exp_dv));
        if (exp_ifv) begin
            check("if_resp_data", if_resp_data, exp_ifd);
            check("if_resp_err", 32'(if_resp_err), 32'(exp_ife));
        end
        if (exp_dv) begin
            check("d_resp_data", d_resp_data, exp_dd);
            check("d_resp_err", 32'(d_resp_err), 32'(exp_de));
        end

        // Who must be granted this cycle.
        merge = (m_merge_cyc == cyc);
        gi = 0; gd = 0;
        if (!merge) begin
            if (if_req_valid && d_req_valid) begin
                gd = !m_last_d;
                gi = m_last_d;
            end else begin
                gi = if_req_valid;
                gd = d_req_valid;
            end
        end
        check("if_req_ready", 32'(if_req_ready), 32'(gi));
        check("d_req_ready", 32'(d_req_ready), 32'(gd));

        exp_rw = 0; exp_addr = 0; exp_din = 0;
        if (merge) begin
            exp_rw = 1; exp_addr = m_pw_addr; exp_din = m_pw_data;
            ref_mem[(m_pw_addr - BASE) >> 2] = m_pw_data;
            rq.push_back(mk(1, cyc + 1, 32'h0, 0, m_merge_acc));
        end else if (gi) begin
            m_last_d = 0;
            e = bad_addr(if_req_addr);
            rq.push_back(mk(0, cyc + 1, e ? 32'h0 : ref_mem[(if_req_addr - BASE) >> 2], e, cyc));
        end else if (gd) begin
            m_last_d = 1;
            e = bad_addr(d_req_addr);
            idx = int'((d_req_addr - BASE) >> 2);
            if (e) begin
                rq.push_back(mk(1, cyc + 1, 32'h0, 1, cyc));
            end else if (!d_req_we) begin
                rq.push_back(mk(1, cyc + 1, ref_mem[idx], 0, cyc));
            end else if (d_req_wmask == 4'hF) begin
                exp_rw = 1; exp_addr = d_req_addr; exp_din = d_req_wdata;
                ref_mem[idx] = d_req_wdata;
                rq.push_back(mk(1, cyc + 1, 32'h0, 0, cyc));
            end else if (d_req_wmask == 4'h0) begin
                rq.push_back(mk(1, cyc + 1, 32'h0, 0, cyc));
            end else begin
                old = ref_mem[idx];
                wd  = d_req_wdata;
                for (int b = 0; b < 4; b++)
                    if (d_req_wmask[b]) old[8*b +: 8] = wd[8*b +: 8];
                m_pw_addr   = d_req_addr;
                m_pw_data   = old;
                m_merge_cyc = cyc + 1;
                m_merge_acc = cyc;
            end
        end
        check("mem_read_write", 32'(mem_read_write), 32'(exp_rw));
        if (exp_rw) begin
            check("mem_write_address", mem_address, exp_addr);
            check("mem_write_data", mem_data_in, exp_din);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            model_step();
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic if_op(input logic [31:0] a);
        if_req_valid = 1'b1;
        if_req_addr  = a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (if_req_ready) begin
                @(posedge clock);
                #1;
                if_req_valid = 1'b0;
                return;
            end
        end
        check("if_accept_timeout", 32'd0, 32'd1);
        if_req_valid = 1'b0;
    endtask

    task automatic d_op(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] mask);
        d_req_valid = 1'b1;
        d_req_addr  = a;
        d_req_we    = we;
        d_req_wdata = wd;
        d_req_wmask = mask;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (d_req_ready) begin
                @(posedge clock);
                #1;
                d_req_valid = 1'b0;
                return;
            end
        end
        check("d_accept_timeout", 32'd0, 32'd1);
        d_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ sequence
    initial begin
        logic [31:0] w;
        reset = 1'b1;
        if_req_valid = 0; if_req_addr = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_wmask = 0;
        for (int i = 0; i < DEPTH / 4; i++) begin
            w = {16'hC0DE, 16'(i)};
            if (i == 0) w = 32'h0050_0093;
            if (i == 4) w = 32'h1122_3344;
            ref_mem[i] = w;
            for (int b = 0; b < 4; b++) tb_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        idle(1);

        // Fetch read.
        if_op(32'h0100_0000);
        idle(3);
        check("fetch_data", last_if_data, 32'h0050_0093);
        check("fetch_err", 32'(last_if_err), 32'd0);

        // Tie: data wins first after reset, then fetch.
        fork
            if_op(32'h0100_0004);
            d_op(32'h0100_0008, 1'b0, 32'h0, 4'h0);
        join
        idle(3);
        check("tie_d_data", last_d_data, 32'hC0DE_0002);
        check("tie_if_data", last_if_data, 32'hC0DE_0001);
        check("tie_order", 32'(last_if_cyc - last_d_cyc), 32'd1);

        // Partial store with a competing fetch held off by MERGE.
        fork
            d_op(32'h0100_0010, 1'b1, 32'hAABB_CCDD, 4'b0101);
            if_op(32'h0100_000C);
        join
        idle(3);
        check("partial_mem_word", tb_word(32'h0100_0010), 32'h11BB_33DD);
        check("partial_latency", 32'(last_d_lat), 32'd2);
        check("partial_fetch_data", last_if_data, 32'hC0DE_0003);
        d_op(32'h0100_0010, 1'b0, 32'h0, 4'h0);
        idle(3);
        check("partial_readback", last_d_data, 32'h11BB_33DD);

        // Error cases and the last valid word.
        d_op(32'h0100_0002, 1'b0, 32'h0, 4'h0);
        idle(3);
        check("misaligned_err", 32'(last_d_err), 32'd1);
        check("misaligned_data", last_d_data, 32'h0);
        if_op(32'h0000_0000);
        idle(3);
        check("below_base_err", 32'(last_if_err), 32'd1);
        d_op(32'h0100_1000, 1'b1, 32'h5555_5555, 4'hF);
        idle(3);
        check("past_end_store_err", 32'(last_d_err), 32'd1);
        d_op(32'h0100_0FFC, 1'b0, 32'h0, 4'h0);
        idle(3);
        check("last_word_data", last_d_data, 32'hC0DE_03FF);
        check("last_word_err", 32'(last_d_err), 32'd0);

        // Full store followed immediately by a load of the same word.
        d_op(32'h0100_0020, 1'b1, 32'hDEAD_BEEF, 4'hF);
        d_op(32'h0100_0020, 1'b0, 32'h0, 4'h0);
        idle(3);
        check("store_load_data", last_d_data, 32'hDEAD_BEEF);
        check("store_mem_word", tb_word(32'h0100_0020), 32'hDEAD_BEEF);

        // Zero-mask store leaves memory alone.
        d_op(32'h0100_0030, 1'b1, 32'hFFFF_FFFF, 4'h0);
        idle(3);
        check("zero_mask_mem_word", tb_word(32'h0100_0030), 32'hC0DE_000C);
        check("zero_mask_err", 32'(last_d_err), 32'd0);

        // Reset during MERGE drops the write.
        d_op(32'h0100_0040, 1'b1, 32'h1234_5678, 4'b0011);
        check("merge_rw_before_reset", 32'(mem_read_write), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_drops_write", 32'(mem_read_write), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        check("reset_mem_word", tb_word(32'h0100_0040), 32'hC0DE_0010);
        d_op(32'h0100_0040, 1'b0, 32'h0, 4'h0);
        idle(3);
        check("reset_readback", last_d_data, 32'hC0DE_0010);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
